// File: rtl/mem_lsu_pkg.sv
// Shared constants, bus payload type and access-size helpers for the MEM-stage load/store unit.
package mem_lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned SEL_W  = XLEN / 8;
  localparam int unsigned HOLD_W = 3;
  localparam int unsigned ST_W   = 2;

  localparam logic [HOLD_W-1:0] HOLD_ID   = 3'b011;
  localparam logic [HOLD_W-1:0] HOLD_NONE = 3'b000;

  localparam logic RIB_REQ  = 1'b1;
  localparam logic RIB_NREQ = 1'b0;

  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;
  localparam logic [2:0] INST_SB  = 3'b000;
  localparam logic [2:0] INST_SH  = 3'b001;
  localparam logic [2:0] INST_SW  = 3'b010;

  localparam logic [ST_W-1:0] MEM_IDLE = 2'b00;
  localparam logic [ST_W-1:0] MEM_BUS  = 2'b01;
  localparam logic [ST_W-1:0] MEM_DONE = 2'b10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } acc_size_e;

  typedef struct packed {
    logic             we;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
    logic [SEL_W-1:0] sel;
  } rib_req_t;

  // Undefined encodings fall back to a full word access.
  function automatic acc_size_e acc_size(input logic we, input logic [2:0] funct3);
    acc_size_e sz;
    sz = SZ_WORD;
    if (we) begin
      case (funct3)
        INST_SB: sz = SZ_BYTE;
        INST_SH: sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (funct3)
        INST_LB, INST_LBU: sz = SZ_BYTE;
        INST_LH, INST_LHU: sz = SZ_HALF;
        default:           sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input logic we, input logic [2:0] funct3,
                                         input logic [1:0] off);
    logic mis;
    case (acc_size(we, funct3))
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lsu_lane_fmt.sv
// Byte-lane strobe / store replication generation and load byte/half extraction with extension.
module mem_lane_fmt
  import mem_lsu_pkg::*;
(
  input  logic             we,
  input  logic [2:0]       funct3,
  input  logic [1:0]       off,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic [SEL_W-1:0] sel_c,
  output logic [XLEN-1:0]  wdata_c,
  output logic [XLEN-1:0]  rdata_c
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Strobes and lane-replicated store data; misaligned halves/words keep their natural lanes.
  always_comb begin
    sel_c   = {SEL_W{1'b1}};
    wdata_c = wdata;
    if (we) begin
      case (acc_size(we, funct3))
        SZ_BYTE: begin
          sel_c   = SEL_W'(4'b0001) << off;
          wdata_c = {4{wdata[7:0]}};
        end
        SZ_HALF: begin
          sel_c   = off[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{wdata[15:0]}};
        end
        default: begin
          sel_c   = {SEL_W{1'b1}};
          wdata_c = wdata;
        end
      endcase
    end
  end

  always_comb begin
    case (off)
      2'b00:   rbyte = rdata[7:0];
      2'b01:   rbyte = rdata[15:8];
      2'b10:   rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
    rhalf = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      INST_LB:  rdata_c = {{24{rbyte[7]}}, rbyte};
      INST_LBU: rdata_c = {24'h000000, rbyte};
      INST_LH:  rdata_c = {{16{rhalf[15]}}, rhalf};
      INST_LHU: rdata_c = {16'h0000, rhalf};
      default:  rdata_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues RIB req/ack transfers and stalls the pipeline while busy.
// Optional misaligned-access trap enabled with `define MEM_MISALIGN_TRAP_EN (adds misalign_o).
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter logic [HOLD_W-1:0] HOLD_CODE = HOLD_ID
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  input  logic [2:0]        mem_funct3_i,
  output logic              rib_req_o,
  output logic              rib_we_o,
  output logic [XLEN-1:0]   rib_addr_o,
  output logic [XLEN-1:0]   rib_wdata_o,
  output logic [SEL_W-1:0]  rib_sel_o,
  input  logic              rib_ack_i,
  input  logic              rib_err_i,
  input  logic [XLEN-1:0]   rib_rdata_i,
  output logic [XLEN-1:0]   mem_reg_wdata_o,
  output logic              me_req_flag_o,
  output logic [HOLD_W-1:0] hold_flag_o,
  output logic              bus_err_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);

  logic [ST_W-1:0]   state_q, state_d;
  logic              req_q, req_d;
  rib_req_t          bus_q, bus_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              flag_q, flag_d;
  logic              err_q, err_d;
  logic [HOLD_W-1:0] hold_c;
  logic              idle_c;
  logic              trap_c;

  logic              fmt_we;
  logic [2:0]        fmt_funct3;
  logic [1:0]        fmt_off;
  logic [SEL_W-1:0]  fmt_sel_c;
  logic [XLEN-1:0]   fmt_wdata_c;
  logic [XLEN-1:0]   fmt_rdata_c;

  assign idle_c = (state_q == MEM_IDLE);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_c = is_misaligned(mem_we_i, mem_funct3_i, mem_addr_i[1:0]);
`else
  assign trap_c = 1'b0;
`endif

  // One formatter serves the request in IDLE and the captured access while in BUS.
  assign fmt_we     = idle_c ? mem_we_i        : bus_q.we;
  assign fmt_funct3 = idle_c ? mem_funct3_i    : funct3_q;
  assign fmt_off    = idle_c ? mem_addr_i[1:0] : off_q;

  mem_lane_fmt u_lane_fmt (
    .we      (fmt_we),
    .funct3  (fmt_funct3),
    .off     (fmt_off),
    .wdata   (mem_wdata_i),
    .rdata   (rib_rdata_i),
    .sel_c   (fmt_sel_c),
    .wdata_c (fmt_wdata_c),
    .rdata_c (fmt_rdata_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    bus_d    = bus_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    flag_d   = RIB_NREQ;
    err_d    = 1'b0;
    hold_c   = HOLD_NONE;
    case (state_q)
      MEM_IDLE: begin
        if (mem_req_i) begin
          hold_c = HOLD_CODE;
          if (trap_c) begin
            state_d = MEM_DONE;
            rdata_d = '0;
          end else begin
            state_d     = MEM_BUS;
            req_d       = 1'b1;
            bus_d.we    = mem_we_i;
            bus_d.addr  = {mem_addr_i[XLEN-1:2], 2'b00};
            bus_d.wdata = fmt_wdata_c;
            bus_d.sel   = fmt_sel_c;
            funct3_d    = mem_funct3_i;
            off_d       = mem_addr_i[1:0];
          end
        end
      end
      MEM_BUS: begin
        hold_c = HOLD_CODE;
        if (rib_ack_i || rib_err_i) begin
          state_d = MEM_DONE;
          req_d   = 1'b0;
          err_d   = rib_err_i;
          rdata_d = (rib_err_i || bus_q.we) ? '0 : fmt_rdata_c;
          flag_d  = bus_q.we ? RIB_NREQ : RIB_REQ;
        end
      end
      MEM_DONE: begin
        state_d = MEM_IDLE;
      end
      default: begin
        state_d = MEM_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MEM_IDLE;
      req_q    <= 1'b0;
      bus_q    <= '0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      rdata_q  <= '0;
      flag_q   <= RIB_NREQ;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      bus_q    <= bus_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Pulses during the DONE cycle of a trapped access.
  always_ff @(posedge clk) begin
    if (rst) misalign_o <= 1'b0;
    else     misalign_o <= idle_c && mem_req_i && trap_c;
  end
`endif

  assign rib_req_o       = req_q;
  assign rib_we_o        = bus_q.we;
  assign rib_addr_o      = bus_q.addr;
  assign rib_wdata_o     = bus_q.wdata;
  assign rib_sel_o       = bus_q.sel;
  assign mem_reg_wdata_o = rdata_q;
  assign me_req_flag_o   = flag_q;
  assign bus_err_o       = err_q;
  assign hold_flag_o     = hold_c;

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit of the 5-stage core.
- Sits between ex_mem and mem_wb.
- Takes the memory request carried by ex_mem and runs a req/ack transaction on the RIB data bus.
- Formats load data (byte-lane select, sign/zero extend) and hands it to mem_wb as mem_reg_wdata with the me_req flag.
- Holds the pipeline through ctrl while a bus transaction is outstanding.

Parameters:
- XLEN, 32: data/address width. Only 32 is supported.
- HOLD_CODE, 3'b011 (`Hold_Id`): value driven on hold_flag_o while stalling.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- mem_req_i  in  1  ex_mem: current instruction accesses memory
- mem_we_i  in  1  ex_mem: 1 = store, 0 = load
- mem_addr_i  in  32  ex_mem: byte address
- mem_wdata_i  in  32  ex_mem: store data (rs2)
- mem_funct3_i  in  3  ex_mem: LB/LH/LW/LBU/LHU/SB/SH/SW encoding
- rib_req_o  out  1  bus request
- rib_we_o  out  1  bus write enable
- rib_addr_o  out  32  word-aligned bus address {addr[31:2],2'b00}
- rib_wdata_o  out  32  lane-replicated store data
- rib_sel_o  out  4  byte-lane strobes
- rib_ack_i  in  1  bus completes transfer this cycle
- rib_err_i  in  1  bus error, qualifies as completion
- rib_rdata_i  in  32  bus read data, valid with ack
- mem_reg_wdata_o  out  32  to mem_wb: formatted load data
- me_req_flag_o  out  1  to mem_wb: `RIB_REQ` when mem_reg_wdata_o is valid
- hold_flag_o  out  3  to ctrl: HOLD_CODE while stalling, else 3'b000
- bus_err_o  out  1  one-cycle pulse on bus error

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state IDLE; rib_req_o=0; rib_we_o=0; rib_addr_o=0; rib_wdata_o=0; rib_sel_o=0; mem_reg_wdata_o=0; me_req_flag_o=0; hold_flag_o=0; bus_err_o=0.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - If mem_req_i=1: hold_flag_o=HOLD_CODE combinationally. Register the bus fields (we, addr, sel, wdata) and go to BUS. rib_req_o rises the next cycle.
  - If mem_req_i=0: no stall.
- BUS:
  - rib_req_o and all bus fields are held stable; hold_flag_o=HOLD_CODE.
  - On rib_ack_i or rib_err_i: capture formatted rdata into mem_reg_wdata_o (0 on err, or on a store), drop rib_req_o, go to DONE.
  - rib_err_i additionally pulses bus_err_o for 1 cycle.
  - ack and err together are treated as err.
- DONE:
  - hold_flag_o=0, so ex_mem/mem_wb advance at this edge.
  - me_req_flag_o=`RIB_REQ` only for a load; `RIB_NREQ` for a store.
  - Unconditionally return to IDLE. mem_req_i seen in DONE belongs to the finished instruction and is never re-issued.
- Outside DONE, me_req_flag_o=`RIB_NREQ`, so mem_wb selects the ALU result.
- Minimum latency: 3 cycles per access (IDLE→BUS→DONE) with ack in the first BUS cycle. Each extra wait cycle adds 1. There is no timeout.
- Byte-lane strobes, with a = addr[1:0]:
  - SB: 4'b0001<<a
  - SH: a[1] ? 4'b1100 : 4'b0011
  - SW: 4'b1111
  - loads: 4'b1111
- Store data replication: SB → {4{b}}, SH → {2{h}}, SW → word.
- Load formatting:
  - LB/LBU select byte a; LH/LHU select half a[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined funct3 is treated as LW.
- Misaligned addresses (LH/SH with a[0]=1, LW/SW with a≠0) are issued word-aligned, with the half/word truncated to its natural lanes. There is no trap.
- rst in BUS or DONE: return to IDLE next edge, rib_req_o=0. The aborted transfer is dropped and any late ack is ignored.
- ack in IDLE or DONE: ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_o (1 bit).
  - A misaligned access in IDLE does not enter BUS. It goes straight to DONE (1-cycle stall), issues no bus request, and pulses misalign_o for that DONE cycle.
  - mem_reg_wdata_o=0 and me_req_flag_o=`RIB_NREQ`.
- Undefined: the port is absent and misaligned accesses behave as described above.

Decomposition:
- Shared defines.v holds:
  - `Hold_Id`, `RIB_REQ`/`RIB_NREQ`
  - INST_LB..INST_SW funct3 constants
  - state encodings MEM_IDLE/MEM_BUS/MEM_DONE (2 bits)
- One natural sub-module, mem_lane_fmt: pure combinational sel/wdata generation and load extraction/extension. It is reused by the FSM top.

Test Plan:
1. LW @0x100, ack on first BUS cycle, rdata=0xDEADBEEF → rib_sel_o=4'hF; hold for 2 cycles; DONE: mem_reg_wdata_o=0xDEADBEEF, me_req_flag_o=1.
2. LB @0x103, rdata=0x80FF_FF7F; LBU @0x103 → LB gives 0xFFFFFF80; LBU gives 0x00000080.
3. SH @0x202, wdata=0x1234ABCD, ack after 3 waits → rib_sel_o=4'b1100, rib_wdata_o=0xABCDABCD, rib_addr_o=0x200; hold for 5 cycles; me_req_flag_o=0.
4. LW with rib_err_i on the 2nd BUS cycle → bus_err_o pulses 1 cycle; mem_reg_wdata_o=0; FSM returns to IDLE.
5. rst asserted in BUS, ack arrives the following cycle → rib_req_o=0 after the reset edge; ack ignored; all outputs at reset values.
6. Back-to-back LW/SW with no gap; ALU-only instruction in between → each access issued exactly once; me_req_flag_o=0 for the ALU instruction; hold_flag_o never asserted for it.
